// File: rtl/program_counter_stack_if.sv
// Control/status bundle between AP_ctrl (master) and the program counter
// (slave).
//   master drives: fetch handshake (ins_inp_valid, ins_cache_rdy, ins_sent),
//                  load_times, and the jmp/call/ret/iret requests with their
//                  byte-address targets. It also drives the interrupt level
//                  int_req.
//   slave drives:  addr_ins, addr_cur_ins, stack_depth, int_active,
//                  stack_ovf, stack_udf, fetch_stall, prog_done.
interface program_counter_stack_if #(
  parameter int ADDR_WIDTH_MEM  = 16,
  parameter int DDR_ADDR_WIDTH  = 28,
  parameter int STACK_PTR_WIDTH = 4,
  parameter int LOAD_CNT_WIDTH  = 10
);
  logic                       ins_inp_valid;
  logic                       ins_cache_rdy;
  logic                       ins_sent;
  logic [LOAD_CNT_WIDTH-1:0]  load_times;
  logic                       jmp_valid;
  logic [DDR_ADDR_WIDTH-1:0]  jmp_addr;
  logic                       call_valid;
  logic [DDR_ADDR_WIDTH-1:0]  call_addr;
  logic                       ret_valid;
  logic                       iret_valid;
  // Interrupt request level; "int" is a reserved word, hence int_req.
  logic                       int_req;

  logic [ADDR_WIDTH_MEM-1:0]  addr_ins;
  logic [ADDR_WIDTH_MEM-1:0]  addr_cur_ins;
  logic [STACK_PTR_WIDTH-1:0] stack_depth;
  logic                       int_active;
  logic                       stack_ovf;
  logic                       stack_udf;
  logic                       fetch_stall;
  logic                       prog_done;

  modport master (
    output ins_inp_valid, ins_cache_rdy, ins_sent, load_times,
           jmp_valid, jmp_addr, call_valid, call_addr,
           ret_valid, iret_valid, int_req,
    input  addr_ins, addr_cur_ins, stack_depth, int_active,
           stack_ovf, stack_udf, fetch_stall, prog_done
  );

  modport slave (
    input  ins_inp_valid, ins_cache_rdy, ins_sent, load_times,
           jmp_valid, jmp_addr, call_valid, call_addr,
           ret_valid, iret_valid, int_req,
    output addr_ins, addr_cur_ins, stack_depth, int_active,
           stack_ovf, stack_udf, fetch_stall, prog_done
  );
endinterface

// File: rtl/program_counter_stack.sv
// Instruction program counter with hardware return stack.
// Produces the instruction-cache fetch address (addr_ins) and the current
// instruction address (addr_cur_ins). Supports call/ret through a return
// stack, edge-detected interrupts entering at INT_VECTOR with iret, byte
// address jumps scaled by INS_SHIFT, and sticky stack overflow/underflow.
// Ports:
//   clk  - system clock, all state on the rising edge
//   rst  - asynchronous active-low reset
//   bus  - slave side of program_counter_stack_if (requests in, status out)
module program_counter_stack #(
  parameter int ADDR_WIDTH_MEM  = 16,
  parameter int ISA_DEPTH       = 64,
  parameter int TOTAL_ISA_DEPTH = 128,
  parameter int DDR_ADDR_WIDTH  = 28,
  parameter int INS_SHIFT       = 3,
  parameter int STACK_DEPTH     = 8,
  parameter int STACK_PTR_WIDTH = 4,
  parameter int LOAD_CNT_WIDTH  = 10,
  parameter int INT_VECTOR      = 112
) (
  input logic                    clk,
  input logic                    rst,
  program_counter_stack_if.slave bus
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int WIN_W = ADDR_WIDTH_MEM + LOAD_CNT_WIDTH;

  localparam logic [STACK_PTR_WIDTH-1:0] DEPTH_FULL = STACK_PTR_WIDTH'(STACK_DEPTH);
  localparam logic [ADDR_WIDTH_MEM-1:0]  PROG_END   = ADDR_WIDTH_MEM'(TOTAL_ISA_DEPTH);
  localparam logic [ADDR_WIDTH_MEM-1:0]  INT_VEC    = ADDR_WIDTH_MEM'(INT_VECTOR);
  localparam logic [WIN_W-1:0]           WIN_SIZE   = WIN_W'(ISA_DEPTH);

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_INT_ENTRY,
    ACT_IRET,
    ACT_RET,
    ACT_CALL,
    ACT_JMP,
    ACT_ADVANCE
  } action_e;

  function automatic logic [ADDR_WIDTH_MEM-1:0] target(
    input logic [DDR_ADDR_WIDTH-1:0] byte_addr
  );
    return ADDR_WIDTH_MEM'(byte_addr >> INS_SHIFT);
  endfunction

  logic [ADDR_WIDTH_MEM-1:0]  addr_ins_q, addr_ins_d;
  logic [ADDR_WIDTH_MEM-1:0]  addr_cur_ins_q, addr_cur_ins_d;
  logic [STACK_PTR_WIDTH-1:0] sp_q, sp_d;
  logic                       int_active_q, int_active_d;
  logic                       stack_ovf_q, stack_ovf_d;
  logic                       stack_udf_q, stack_udf_d;
  logic                       int_pend_q, int_pend_d;
  logic                       int_d_q, int_d_d;

  logic [ADDR_WIDTH_MEM-1:0]  stack_mem [STACK_DEPTH];

  action_e                    action;
  logic                       push_en;
  logic                       stack_full;
  logic                       stack_empty;
  logic [STACK_PTR_WIDTH-1:0] sp_dec;
  logic [ADDR_WIDTH_MEM-1:0]  pop_data;
  logic [WIN_W-1:0]           win_limit;
  logic                       at_window_end;
  logic                       below_end;
  logic                       int_rise;
  logic                       pend_eff;

  assign stack_full    = (sp_q >= DEPTH_FULL);
  assign stack_empty   = (sp_q == '0);
  assign sp_dec        = sp_q - STACK_PTR_WIDTH'(1);
  assign pop_data      = stack_mem[sp_dec[IDX_W-1:0]];

  // Window limit kept at full product width so large load_times never alias.
  assign win_limit     = WIN_SIZE * WIN_W'(bus.load_times);
  assign at_window_end = ({{LOAD_CNT_WIDTH{1'b0}}, addr_ins_q} == win_limit);
  assign below_end     = (addr_ins_q < PROG_END);

  // An edge seen this cycle is serviceable in the same cycle, so the
  // interrupt enters one clock after int rises and beats a colliding call/jmp.
  assign int_rise      = bus.int_req & ~int_d_q;
  assign pend_eff      = int_pend_q | int_rise;

  always_comb begin
    action = ACT_HOLD;
    if (pend_eff && !int_active_q && !stack_full) begin
      action = ACT_INT_ENTRY;
    end else if (bus.iret_valid && int_active_q) begin
      action = ACT_IRET;
    end else if (bus.ret_valid) begin
      action = ACT_RET;
    end else if (bus.call_valid) begin
      action = ACT_CALL;
    end else if (bus.jmp_valid) begin
      action = ACT_JMP;
    end else if (bus.ins_inp_valid && bus.ins_cache_rdy && bus.ins_sent &&
                 below_end && !at_window_end) begin
      action = ACT_ADVANCE;
    end
  end

  always_comb begin
    addr_ins_d     = addr_ins_q;
    sp_d           = sp_q;
    int_active_d   = int_active_q;
    stack_ovf_d    = stack_ovf_q;
    stack_udf_d    = stack_udf_q;
    push_en        = 1'b0;

    unique case (action)
      ACT_INT_ENTRY: begin
        push_en      = 1'b1;
        sp_d         = sp_q + STACK_PTR_WIDTH'(1);
        addr_ins_d   = INT_VEC;
        int_active_d = 1'b1;
      end
      ACT_IRET: begin
        int_active_d = 1'b0;
        if (stack_empty) begin
          stack_udf_d = 1'b1;
        end else begin
          addr_ins_d = pop_data;
          sp_d       = sp_dec;
        end
      end
      ACT_RET: begin
        if (stack_empty) begin
          stack_udf_d = 1'b1;
        end else begin
          addr_ins_d = pop_data;
          sp_d       = sp_dec;
        end
      end
      ACT_CALL: begin
        if (stack_full) begin
          stack_ovf_d = 1'b1;
        end else begin
          push_en    = 1'b1;
          sp_d       = sp_q + STACK_PTR_WIDTH'(1);
          addr_ins_d = target(bus.call_addr);
        end
      end
      ACT_JMP:     addr_ins_d = target(bus.jmp_addr);
      ACT_ADVANCE: addr_ins_d = addr_ins_q + ADDR_WIDTH_MEM'(1);
      default:     ;
    endcase

    addr_cur_ins_d = addr_ins_d;
    int_pend_d     = pend_eff & (action != ACT_INT_ENTRY);
    int_d_d        = bus.int_req;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_ins_q     <= '0;
      addr_cur_ins_q <= '0;
      sp_q           <= '0;
      int_active_q   <= 1'b0;
      stack_ovf_q    <= 1'b0;
      stack_udf_q    <= 1'b0;
      int_pend_q     <= 1'b0;
      int_d_q        <= 1'b0;
    end else begin
      addr_ins_q     <= addr_ins_d;
      addr_cur_ins_q <= addr_cur_ins_d;
      sp_q           <= sp_d;
      int_active_q   <= int_active_d;
      stack_ovf_q    <= stack_ovf_d;
      stack_udf_q    <= stack_udf_d;
      int_pend_q     <= int_pend_d;
      int_d_q        <= int_d_d;
    end
  end

  // Stack storage needs no reset; only entries below sp_q are ever read.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_mem[sp_q[IDX_W-1:0]] <= addr_ins_q;
    end
  end

  assign bus.addr_ins     = addr_ins_q;
  assign bus.addr_cur_ins = addr_cur_ins_q;
  assign bus.stack_depth  = sp_q;
  assign bus.int_active   = int_active_q;
  assign bus.stack_ovf    = stack_ovf_q;
  assign bus.stack_udf    = stack_udf_q;
  assign bus.fetch_stall  = bus.ins_inp_valid & at_window_end & below_end;
  assign bus.prog_done    = (addr_ins_q == PROG_END);

endmodule

// File: doc/program_counter_stack.md
Name: program_counter_stack

Overview:
- Next-generation instruction program counter for the AP controller.
- Generates the instruction-cache fetch address `addr_ins` and the current-instruction address `addr_cur_ins`.
- Adds a parametrised hardware return stack for call/ret, synchronous edge-detected interrupts with a fixed vector and iret, jump-byte-address scaling, and stack-error and done status.
- Sits between AP_ctrl and the instruction cache.

Parameters:
- ADDR_WIDTH_MEM, 16, instruction address width.
- ISA_DEPTH, 64, instructions per cache load window.
- TOTAL_ISA_DEPTH, 128, program length; fetch stops at this address.
- DDR_ADDR_WIDTH, 28, width of byte-address jump/call targets.
- INS_SHIFT, 3, log2 bytes per instruction; target = byte address >> INS_SHIFT.
- STACK_DEPTH, 8, return-stack entries.
- STACK_PTR_WIDTH, 4, width of stack_depth; must hold STACK_DEPTH.
- LOAD_CNT_WIDTH, 10, width of load_times.
- INT_VECTOR, 112, instruction address of the interrupt handler.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous active-low reset
- ins_inp_valid  in  1  AP_ctrl ready to accept instructions
- ins_cache_rdy  in  1  instruction cache ready
- ins_sent  in  1  cache is in its SENT_INS state
- load_times  in  LOAD_CNT_WIDTH  number of windows loaded into cache
- jmp_valid  in  1  one-cycle jump request
- jmp_addr  in  DDR_ADDR_WIDTH  jump byte address
- call_valid  in  1  one-cycle call request
- call_addr  in  DDR_ADDR_WIDTH  call byte address
- ret_valid  in  1  one-cycle return request
- iret_valid  in  1  one-cycle interrupt-return request
- int  in  1  interrupt request level, synchronous to clk
- addr_ins  out  ADDR_WIDTH_MEM  fetch address to cache (registered)
- addr_cur_ins  out  ADDR_WIDTH_MEM  current instruction address (registered)
- stack_depth  out  STACK_PTR_WIDTH  valid stack entries
- int_active  out  1  handler executing
- stack_ovf  out  1  sticky push-while-full
- stack_udf  out  1  sticky pop-while-empty
- fetch_stall  out  1  combinational: ins_inp_valid and blocked at window end
- prog_done  out  1  addr_ins == TOTAL_ISA_DEPTH

Behaviour:
- Reset (rst=0, async): all outputs, stack pointer, int_pend and int_d cleared to 0. Stack RAM contents are don't-care. Reset mid-ISR or mid-call abandons all state.
- Interrupt detection: int_d <= int each cycle. A rising edge (int & !int_d) sets int_pend. int_pend clears only when the interrupt is serviced. A held-high int does not re-trigger.
- Target computation: T(x) = (x >> INS_SHIFT), truncated to ADDR_WIDTH_MEM.
- Per-cycle action, highest priority first; exactly one action per cycle:
  1. INT_ENTRY: int_pend & !int_active & depth<STACK_DEPTH. Push addr_ins; addr_ins = addr_cur_ins = INT_VECTOR; int_active=1; clear int_pend. If the stack is full, entry is deferred, int_pend is held, and no flag is set.
  2. IRET: iret_valid & int_active. Pop into addr_ins and addr_cur_ins; int_active=0. If empty: stack_udf=1, int_active=0, address unchanged. iret_valid with int_active=0 is ignored.
  3. RET: ret_valid. Pop into addr_ins and addr_cur_ins. If empty: stack_udf=1, no change.
  4. CALL: call_valid. Push addr_ins; addr_ins = addr_cur_ins = T(call_addr). If full: stack_ovf=1, no push, no redirect.
  5. JMP: jmp_valid. addr_ins = addr_cur_ins = T(jmp_addr).
  6. ADVANCE: ins_inp_valid & ins_cache_rdy & ins_sent & addr_ins<TOTAL_ISA_DEPTH & addr_ins != ISA_DEPTH*load_times. Then addr_ins = addr_cur_ins = addr_ins+1.
  7. Otherwise hold.
- Lower-priority requests in the same cycle are dropped, not queued (only the interrupt is pended).
- Push/pop timing: a push writes stack[depth] then depth+1; a pop reads stack[depth-1] then depth-1. Both complete in one cycle, and the result is visible on the next edge.
- Window limit: the ISA_DEPTH*load_times product is computed at ADDR_WIDTH_MEM+LOAD_CNT_WIDTH bits, with no truncation.
- fetch_stall = ins_inp_valid & addr_ins == ISA_DEPTH*load_times & addr_ins < TOTAL_ISA_DEPTH.
- Fetch resumes the cycle after load_times increments.
- stack_ovf and stack_udf are cleared only by reset.
- prog_done is combinational from addr_ins. Redirections still work while prog_done=1.

Test Plan:
- Reset then sequential fetch: rst low→high; load_times=1, ins_inp_valid=ins_cache_rdy=ins_sent=1 → addr_ins steps 0..64, then holds at 64 with fetch_stall=1. Set load_times=2 → advances to 128, prog_done=1, stall=0.
- Call/return: at addr_ins=10, call_addr=0x100 → addr_ins=32, depth=1. Later ret_valid → addr_ins=10, depth=0.
- Stack limits: 8 calls → depth=8; 9th call → stack_ovf=1, addr unchanged. 9 rets from depth 8 → 9th sets stack_udf=1.
- Interrupt: int rises at addr_ins=20 → next cycle addr_ins=112, int_active=1, depth+1. Second edge during ISR stays pending. iret → addr_ins=20; the pending interrupt enters the next cycle.
- Priority collision: int edge + call_valid + jmp_valid in one cycle → INT_ENTRY taken, call/jmp dropped. ret_valid+jmp_valid → ret wins.
- Async reset mid-ISR at depth=3: rst low between clock edges → all outputs 0 immediately, no clock needed.
